// File: rtl/count_tick_ctrl.sv
// Button-driven run/step control: debounces run/step buttons and issues one-cycle counter ticks,
// either periodically while running or once per step press while idle.
module count_tick_ctrl #(
  parameter int unsigned DIV       = 50_000_000,
  parameter int unsigned PRESC_W   = 26,
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned DB_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_step,
  output logic       tick,
  output logic       running,
  output logic [7:0] tick_cnt
);

  localparam logic [DB_W-1:0]    DbLast    = DB_W'(DB_CYCLES - 1);
  localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(DIV - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  // Bit 0 carries the run button, bit 1 the step button.
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            stable_q, stable_dly_q;
  logic [1:0][DB_W-1:0]  dcnt_q;
  logic [1:0]            press;
  logic                  run_press, step_press;

  state_e                state_q, state_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  tick_q, tick_d;
  logic [7:0]            tick_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      dcnt_q       <= '0;
    end else begin
      sync1_q      <= {btn_step, btn_run};
      sync2_q      <= sync1_q;
      stable_dly_q <= stable_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DbLast) begin
          stable_q[i] <= sync2_q[i];
          dcnt_q[i]   <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign press      = stable_q & ~stable_dly_q;
  assign run_press  = press[0];
  assign step_press = press[1];

  // A run press always wins; the prescaler restarts from zero on every transition.
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    tick_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_press) begin
          state_d = StRun;
        end else if (step_press) begin
          tick_d = 1'b1;
        end
      end
      StRun: begin
        if (run_press) begin
          state_d = StIdle;
        end else begin
          tick_d  = (presc_q == PrescLast);
          presc_d = (presc_q == PrescLast) ? '0 : presc_q + PRESC_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      if (tick_q) begin
        tick_cnt_q <= tick_cnt_q + 8'd1;
      end
    end
  end

  assign tick     = tick_q;
  assign running  = (state_q == StRun);
  assign tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_count_tick_ctrl.sv
// Directed bench for count_tick_ctrl: segment table for reset/debounce, hand sequences for
// run cadence, stepping, simultaneous presses, pause, wrap and mid-run reset.
module tb_count_tick_ctrl;

  localparam int unsigned DIV       = 4;
  localparam int unsigned PRESC_W   = 3;
  localparam int unsigned DB_CYCLES = 3;
  localparam int unsigned DB_W      = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_run;
  logic       btn_step;
  logic       tick;
  logic       running;
  logic [7:0] tick_cnt;

  count_tick_ctrl #(
    .DIV       (DIV),
    .PRESC_W   (PRESC_W),
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_run  (btn_run),
    .btn_step (btn_step),
    .tick     (tick),
    .running  (running),
    .tick_cnt (tick_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic run;
    logic step;
    int   cycles;
    logic exp_running;
    int   exp_ticks;
    int   exp_cnt;
  } seg_t;

  seg_t segs[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Observation window: tick count, index of first tick, spacing and width errors.
  int win_ticks, win_first, win_idx, win_last;
  bit win_bad_gap, win_wide, win_prev;

  function automatic seg_t mk_seg(input logic r, input logic ru, input logic st, input int cyc,
                                  input logic er, input int et, input int ec);
    seg_t s;
    s.rst = r; s.run = ru; s.step = st; s.cycles = cyc;
    s.exp_running = er; s.exp_ticks = et; s.exp_cnt = ec;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic win_start();
    win_ticks = 0; win_first = 0; win_idx = 0; win_last = 0;
    win_bad_gap = 1'b0; win_wide = 1'b0; win_prev = 1'b0;
  endtask

  task automatic tick_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      win_idx++;
      if (tick === 1'b1) begin
        win_ticks++;
        if (win_first == 0) win_first = win_idx;
        if (win_last != 0 && (win_idx - win_last) != int'(DIV)) win_bad_gap = 1'b1;
        if (win_prev) win_wide = 1'b1;
        win_last = win_idx;
      end
      win_prev = (tick === 1'b1);
    end
  endtask

  task automatic press(input logic r, input logic s, input int hold, input int gap);
    btn_run  = r;
    btn_step = s;
    tick_cycles(hold);
    btn_run  = 1'b0;
    btn_step = 1'b0;
    tick_cycles(gap);
  endtask

  initial begin
    int   first_run;
    bit   found;
    int   p_ticks;
    logic r5, r6, t6;
    int   seen;

    rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0;

    // Reset with toggling buttons, first cycle after release, then 10 short glitches.
    segs.push_back(mk_seg(1'b1, 1'b1, 1'b1, 1, 1'b0, 0, 0));
    segs.push_back(mk_seg(1'b1, 1'b0, 1'b1, 1, 1'b0, 0, 0));
    segs.push_back(mk_seg(1'b0, 1'b0, 1'b0, 1, 1'b0, 0, 0));
    for (int k = 0; k < 10; k++) begin
      segs.push_back(mk_seg(1'b0, 1'b1, 1'b0, 2, 1'b0, 0, 0));
      segs.push_back(mk_seg(1'b0, 1'b0, 1'b0, 2, 1'b0, 0, 0));
    end

    foreach (segs[i]) begin
      rst = segs[i].rst; btn_run = segs[i].run; btn_step = segs[i].step;
      win_start();
      tick_cycles(segs[i].cycles);
      check($sformatf("seg%0d_running", i), {31'b0, running}, {31'b0, segs[i].exp_running});
      check($sformatf("seg%0d_ticks", i), win_ticks, segs[i].exp_ticks);
      check($sformatf("seg%0d_cnt", i), {24'b0, tick_cnt}, segs[i].exp_cnt);
    end

    // Held run press: accepted once, 3..6 cycles after the raw edge.
    first_run = 0;
    btn_run = 1'b1;
    for (int i = 1; i <= 10 && first_run == 0; i++) begin
      @(negedge clk);
      if (running === 1'b1) first_run = i;
    end
    btn_run = 1'b0;
    check("run_accept_latency", {31'b0, (first_run >= 3 && first_run <= 6)}, 1);

    // Free-running cadence: first tick 4 cycles after running, then every 4.
    win_start();
    tick_cycles(41);
    check("run_ticks", win_ticks, 10);
    check("run_first_tick", win_first, 4);
    check("run_gap_err", {31'b0, win_bad_gap}, 0);
    check("run_wide_err", {31'b0, win_wide}, 0);
    check("run_cnt", {24'b0, tick_cnt}, 10);
    check("run_running", {31'b0, running}, 1);

    // Pause landing in the presc==DIV-1 cycle suppresses that tick.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (tick === 1'b1) found = 1'b1;
    end
    check("pause_tick_found", {31'b0, found}, 1);
    @(negedge clk);
    @(negedge clk);
    btn_run = 1'b1;
    p_ticks = 0; r5 = 1'bx; r6 = 1'bx; t6 = 1'bx;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (tick === 1'b1) p_ticks++;
      if (i == 5) r5 = running;
      if (i == 6) begin r6 = running; t6 = tick; end
    end
    btn_run = 1'b0;
    check("pause_ticks", p_ticks, 1);
    check("pause_running_before", {31'b0, r5}, 1);
    check("pause_running_after", {31'b0, r6}, 0);
    check("pause_tick_suppressed", {31'b0, t6}, 0);
    win_start();
    tick_cycles(10);
    check("idle_ticks", win_ticks, 0);
    check("idle_running", {31'b0, running}, 0);
    check("idle_cnt", {24'b0, tick_cnt}, 12);

    // Single steps in IDLE: tick one cycle after the accepted press.
    for (int k = 0; k < 3; k++) begin
      win_start();
      press(1'b0, 1'b1, 6, 8);
      check($sformatf("step%0d_ticks", k), win_ticks, 1);
      check($sformatf("step%0d_first", k), win_first, 6);
    end
    check("step_running", {31'b0, running}, 0);
    check("step_cnt", {24'b0, tick_cnt}, 15);

    // Run and step together: enters RUN, no step tick.
    win_start();
    press(1'b1, 1'b1, 6, 8);
    check("both_ticks", win_ticks, 2);
    check("both_first", win_first, 10);
    check("both_running", {31'b0, running}, 1);
    check("both_cnt", {24'b0, tick_cnt}, 16);

    // Step press during RUN leaves the cadence untouched.
    win_start();
    press(1'b0, 1'b1, 6, 8);
    check("runstep_ticks", win_ticks, 3);
    check("runstep_first", win_first, 4);
    check("runstep_gap_err", {31'b0, win_bad_gap}, 0);
    check("runstep_cnt", {24'b0, tick_cnt}, 20);

    // Wrap the tally through 8'hFF.
    seen = 0;
    for (int c = 0; c < 236 * 4 + 20 && seen < 236; c++) begin
      @(negedge clk);
      if (tick === 1'b1) seen++;
    end
    check("wrap_ticks_seen", seen, 236);
    @(negedge clk);
    check("wrap_cnt", {24'b0, tick_cnt}, 0);

    // Reset mid-prescale.
    seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(negedge clk);
      if (tick === 1'b1) seen++;
    end
    @(negedge clk);
    check("prerst_cnt", {24'b0, tick_cnt}, 2);
    check("prerst_running", {31'b0, running}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_tick", {31'b0, tick}, 0);
    check("rst_running", {31'b0, running}, 0);
    check("rst_cnt", {24'b0, tick_cnt}, 0);
    win_start();
    tick_cycles(12);
    check("postrst_ticks", win_ticks, 0);
    check("postrst_running", {31'b0, running}, 0);

    // Fresh run press after reset.
    win_start();
    press(1'b1, 1'b0, 6, 8);
    check("rerun_first", win_first, 10);
    check("rerun_ticks", win_ticks, 2);
    check("rerun_running", {31'b0, running}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
